// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types for the instruction fetch queue: prefetch entry layout and the NOP
// that is shown on the IF stage whenever no entry is valid.
package Pipe_Buf_Reg_PKG;

  localparam int unsigned FE_PC_W  = 9;
  localparam int unsigned FE_INS_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FE_PC_W-1:0]  pc;
    logic [FE_INS_W-1:0] instr;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch storage: DEPTH-entry circular buffer of fetch entries with push, pop,
// flush and an occupancy count. Push and pop may coincide, even when full.
module fetch_fifo
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry               wdata,
  output fetch_entry               rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointers and count; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID register.
// Define FETCH_BYPASS_EN to forward a response straight to if_* when the queue is empty.
module instr_fetch_queue
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned INS_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INS_W-1:0]  if_instr
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned SW  = CW + 1;
  localparam int unsigned STW = CW + 2;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [STW-1:0]  stale;
  logic [PC_W-1:0] resp_pc;
  logic            grant;
  logic            resp_live;
  logic            head_valid;
  logic            bypass;
  logic            push;
  logic            pop;
  fetch_entry      wentry;
  fetch_entry      head;

  // Request gating, response routing and IF-stage presentation.
  always_comb begin
    imem_req   = reset && !redirect && ((SW'(outstanding) + SW'(count)) < SW'(DEPTH));
    grant      = imem_req && imem_gnt;
    resp_live  = imem_rvalid && (stale == '0);
    head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass     = reset && resp_live && !head_valid && !redirect;
`else
    bypass     = 1'b0;
`endif
    pop          = head_valid && !stall && !redirect;
    push         = resp_live && !redirect && !(bypass && !stall);
    wentry.pc    = FE_PC_W'(resp_pc);
    wentry.instr = FE_INS_W'(imem_rdata);
    if_valid     = head_valid || bypass;
    if_pc        = '0;
    if_instr     = INS_W'(NOP_INSTR);
    if (bypass) begin
      if_pc    = resp_pc;
      if_instr = imem_rdata;
    end else if (head_valid) begin
      if_pc    = PC_W'(head.pc);
      if_instr = INS_W'(head.instr);
    end
  end

  // Fetch address, response PC and in-flight bookkeeping. Responses return in
  // grant order, so all stale ones precede the first live one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_addr   <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      stale       <= '0;
    end else if (redirect) begin
      imem_addr   <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= '0;
      stale       <= stale + STW'(outstanding) - STW'(imem_rvalid);
    end else begin
      if (grant)                    imem_addr <= imem_addr + PC_W'(4);
      if (resp_live)                resp_pc   <= resp_pc + PC_W'(4);
      if (imem_rvalid && !resp_live) stale    <= stale - STW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(resp_live);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an in-order memory with random grant and
// latency feeds the DUT; a stream-level model predicts every fetch and IF output.
module tb_instr_fetch_queue;
  import Pipe_Buf_Reg_PKG::*;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned INS_W = 32;
  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INS_W-1:0]  imem_rdata;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INS_W-1:0]  if_instr;

  instr_fetch_queue #(
    .PC_W  (PC_W),
    .INS_W (INS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned     ready;
    int unsigned     gen;
    logic [PC_W-1:0] addr;
  } resp_t;

  resp_t           pend[$];
  int unsigned     cyc;
  int unsigned     cur_gen;
  int unsigned     occ;
  logic [PC_W-1:0] exp_fetch;
  logic [PC_W-1:0] exp_head;
  int unsigned     errors;
  int unsigned     checks;
  int unsigned     gnt_pct;
  int unsigned     lat_min;
  int unsigned     lat_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory word tagged with the stream generation so stale data is recognisable.
  function automatic logic [31:0] mkdata(input int unsigned gen, input logic [PC_W-1:0] pc);
    logic [31:0] g;
    g = gen;
    return {g[7:0], 15'h0, pc};
  endfunction

  task automatic step(input logic stl, input logic rdr, input logic [PC_W-1:0] rpc);
    logic        rv;
    logic        rv_live;
    logic        g;
    logic        exp_req;
    logic        exp_valid;
    logic        consume;
    int unsigned inflight;
    resp_t       r;
    @(negedge clk);
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    rv          = (pend.size() > 0) && (pend[0].ready <= cyc);
    rv_live     = rv && (pend[0].gen == cur_gen);
    imem_rvalid = rv;
    imem_rdata  = rv ? mkdata(pend[0].gen, pend[0].addr) : 32'h0;
    inflight = 0;
    foreach (pend[i]) if (pend[i].gen == cur_gen) inflight++;
    #1;
    exp_req   = !rdr && ((inflight + occ) < DEPTH);
    exp_valid = (occ > 0) || (BYP && rv_live && !rdr);
    check("imem_req",  32'(imem_req),  32'(exp_req));
    check("imem_addr", 32'(imem_addr), 32'(exp_fetch));
    check("if_valid",  32'(if_valid),  32'(exp_valid));
    check("if_pc",     32'(if_pc),     exp_valid ? 32'(exp_head) : 32'h0);
    check("if_instr",  if_instr,       exp_valid ? mkdata(cur_gen, exp_head) : NOP_INSTR);
    g       = imem_req && imem_gnt;
    consume = exp_valid && !stl && !rdr;
    if (g) begin
      r.ready = cyc + 1 + lat_min + $urandom_range(lat_max - lat_min);
      r.gen   = cur_gen;
      r.addr  = imem_addr;
    end
    if (rv) void'(pend.pop_front());
    if (rdr) begin
      cur_gen++;
      exp_fetch = rpc;
      exp_head  = rpc;
      occ       = 0;
    end else begin
      if (rv_live) occ++;
      if (consume) begin
        occ--;
        exp_head = exp_head + PC_W'(4);
      end
      if (g) exp_fetch = exp_fetch + PC_W'(4);
    end
    if (g) pend.push_back(r);
    cyc++;
  endtask

  task automatic do_reset(input logic with_rv);
    @(negedge clk);
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = with_rv && (pend.size() > 0);
    imem_rdata  = (pend.size() > 0) ? mkdata(pend[0].gen, pend[0].addr) : 32'h0;
    #1;
    check("rst_imem_req",  32'(imem_req),  32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_if_valid",  32'(if_valid),  32'h0);
    check("rst_if_pc",     32'(if_pc),     32'h0);
    check("rst_if_instr",  if_instr,       NOP_INSTR);
    pend.delete();
    occ       = 0;
    cur_gen++;
    exp_fetch = '0;
    exp_head  = '0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    reset       = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; cur_gen = 0; occ = 0;
    exp_fetch = '0; exp_head = '0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    gnt_pct = 100; lat_min = 0; lat_max = 0;

    // Reset release, always-ready memory, 1-cycle response latency.
    do_reset(1'b0);
    repeat (8) step(1'b0, 1'b0, '0);

    // Long decode stall: queue fills, requests stop, head held.
    repeat (6) step(1'b1, 1'b0, '0);
    check("stall_full_req", 32'(imem_req), 32'h0);
    repeat (4) step(1'b0, 1'b0, '0);

    // Redirect with responses in flight.
    lat_min = 1; lat_max = 1;
    repeat (5) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, PC_W'('h040));
    repeat (6) step(1'b0, 1'b0, '0);

    // PC wrap at the top of the address space.
    lat_min = 0; lat_max = 0;
    step(1'b0, 1'b1, PC_W'('h1F8));
    repeat (6) step(1'b0, 1'b0, '0);

    // Redirect, stall and response all in one cycle.
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, PC_W'('h100));
    repeat (5) step(1'b0, 1'b0, '0);

    // Reset mid-burst with a response pending.
    lat_min = 1; lat_max = 2;
    repeat (4) step(1'b0, 1'b0, '0);
    do_reset(1'b1);
    repeat (6) step(1'b0, 1'b0, '0);

    // Random traffic.
    lat_min = 0; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      logic [PC_W-1:0] t;
      if ((n % 500) == 0) gnt_pct = 30 + $urandom_range(70);
      t = PC_W'({$urandom_range(127), 2'b00});
      step(($urandom_range(99) < 30), ($urandom_range(99) < 5), t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program counter width.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  decode hazard stall; head not consumed.
REQ-007 SHALL have port redirect  input  1  branch/jalr taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  PC_W  target of redirect.
REQ-009 SHALL have port imem_req  output  1  fetch request valid.
REQ-010 SHALL have port imem_addr  output  PC_W  fetch byte address.
REQ-011 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  in-order read data valid.
REQ-013 SHALL have port imem_rdata  input  INS_W  fetched instruction.
REQ-014 SHALL have port if_valid  output  1  head entry valid for IF/ID register.
REQ-015 SHALL have port if_pc  output  PC_W  PC of head entry.
REQ-016 SHALL have port if_instr  output  INS_W  head instruction; NOP 32'h00000013 when !if_valid.

Function
REQ-017 SHALL hold imem_req and imem_addr stable until imem_gnt; imem_addr advances by 4 on each grant.
REQ-018 SHALL assert imem_req only when outstanding + occupancy < DEPTH and redirect is low.
REQ-019 SHALL compute PC+4 modulo 2^PC_W (wrap from 9'h1FC to 9'h000).
REQ-020 SHALL write each non-stale imem_rvalid response with its PC into the queue tail, in grant order.
REQ-021 SHALL pop the head when if_valid && !stall && !redirect.
REQ-022 SHALL accept push and pop in the same cycle, occupancy unchanged, including when full.
REQ-023 SHALL on redirect: empty queue next cycle, set fetch PC to redirect_pc, deassert imem_req that cycle, record outstanding responses (excluding a same-cycle rvalid) as stale.
REQ-024 SHALL discard stale responses, decrementing the stale count per rvalid, and never present them.
REQ-025 SHALL give redirect priority over stall, push and pop in the same cycle.
REQ-026 SHALL hold if_valid, if_pc, if_instr unchanged while stall is high and no redirect.
REQ-027 SHALL never overflow: a response arriving when full is impossible by REQ-018.

Reset
REQ-028 SHALL, while reset is low, force fetch PC=0, occupancy=0, outstanding=0, stale=0, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=32'h00000013.
REQ-029 SHALL abandon in-flight requests on reset; first request after release is address 0.

Configuration
REQ-030 SHALL, with FETCH_BYPASS_EN defined, present a non-stale rvalid response on if_* in the same cycle when the queue is empty (0-cycle rdata-to-if latency).
REQ-031 SHALL, without FETCH_BYPASS_EN, always register responses into the queue (1-cycle rdata-to-if latency).

Structure
REQ-032 SHALL place NOP_INSTR constant and fetch_entry struct {pc, instr} in Pipe_Buf_Reg_PKG.
REQ-033 SHALL implement storage in one sub-module fetch_fifo (DEPTH entries, push/pop/flush, count).

Verification
REQ-034 Reset release, gnt=1 always, rvalid 1 cycle after gnt -> addresses 0,4,8,C; if_pc 0 valid by cycle 2 (cycle 3 without bypass).
REQ-035 stall held 6 cycles, memory always ready -> queue fills to 4, imem_req drops, if_pc constant.
REQ-036 redirect to 9'h040 with 2 requests outstanding -> both responses dropped, next if_pc=9'h040.
REQ-037 Fetch from 9'h1F8 -> addresses 1F8, 1FC, 000.
REQ-038 reset asserted mid-burst with rvalid pending -> all outputs to reset values same cycle, refetch from 0.
REQ-039 redirect and stall and rvalid in the same cycle -> queue empty next cycle, no if_valid for old stream.
